// File: rtl/io_port_controller_if.sv
// IO bus between the data manager and the IO port controller.
// The data manager drives the strobes, address and store data; the controller returns read data.
interface io_port_controller_if;
  logic        iDoIoRead;
  logic        iDoIoWrite;
  logic [31:0] iAddress;
  logic [31:0] iWriteData;
  logic [15:0] oReadData;

  modport master (
    output iDoIoRead,
    output iDoIoWrite,
    output iAddress,
    output iWriteData,
    input  oReadData
  );

  modport slave (
    input  iDoIoRead,
    input  iDoIoWrite,
    input  iAddress,
    input  iWriteData,
    output oReadData
  );
endinterface

// File: rtl/io_port_controller.sv
// Memory-mapped IO endpoint: LED register, debounced switch input,
// 8-digit multiplexed seven-segment driver and a sticky illegal-access flag.
module io_port_controller #(
  parameter logic [31:0] IO_BASE         = 32'hFFFFFC00,
  parameter int          DEBOUNCE_CYCLES = 100000,
  parameter int          SCAN_CYCLES     = 100000
) (
  input  logic                       iClock,
  input  logic                       iReset,
  io_port_controller_if.slave        bus,
  input  logic [23:0]                iSwitches,
  output logic [23:0]                oLeds,
  output logic [7:0]                 oSegEnable,
  output logic [7:0]                 oSegCode,
  output logic                       oIoFault
);

  localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_CYCLES - 1);

  logic [23:0]       r_led;
  logic [31:0]       r_seg;
  logic              r_fault;
  logic [23:0]       r_sync1;
  logic [23:0]       r_sync2;
  logic [23:0]       r_cand;
  logic [23:0]       r_stable;
  logic [DEB_W-1:0]  r_deb_cnt;
  logic [SCAN_W-1:0] r_scan_cnt;
  logic [2:0]        r_idx;
  logic [7:0]        r_seg_en;
  logic [7:0]        r_seg_code;

  logic [9:0]  w_off;
  logic        w_in_win;
  logic        w_hit;
  logic        w_off_led_lo;
  logic        w_off_led_hi;
  logic        w_off_sw_lo;
  logic        w_off_sw_hi;
  logic        w_off_seg_lo;
  logic        w_off_seg_hi;
  logic        w_writable;
  logic        w_sw_off;
  logic        w_mapped;
  logic        w_wr_en;
  logic        w_fault_evt;
  logic [15:0] w_rd_data;
  logic        w_unused_wdata;

  function automatic logic [7:0] f_hex(input logic [3:0] n);
    logic [7:0] p;
    case (n)
      4'h0: p = 8'hC0;
      4'h1: p = 8'hF9;
      4'h2: p = 8'hA4;
      4'h3: p = 8'hB0;
      4'h4: p = 8'h99;
      4'h5: p = 8'h92;
      4'h6: p = 8'h82;
      4'h7: p = 8'hF8;
      4'h8: p = 8'h80;
      4'h9: p = 8'h90;
      4'hA: p = 8'h88;
      4'hB: p = 8'h83;
      4'hC: p = 8'hC6;
      4'hD: p = 8'hA1;
      4'hE: p = 8'h86;
      default: p = 8'h8E;
    endcase
    return p;
  endfunction

  assign w_off        = bus.iAddress[9:0];
  assign w_in_win     = (bus.iAddress[31:10] == IO_BASE[31:10]);
  assign w_hit        = (bus.iDoIoRead | bus.iDoIoWrite) & w_in_win;
  assign w_off_led_lo = (w_off == 10'h060);
  assign w_off_led_hi = (w_off == 10'h062);
  assign w_off_sw_lo  = (w_off == 10'h070);
  assign w_off_sw_hi  = (w_off == 10'h072);
  assign w_off_seg_lo = (w_off == 10'h080);
  assign w_off_seg_hi = (w_off == 10'h082);
  assign w_writable   = w_off_led_lo | w_off_led_hi | w_off_seg_lo | w_off_seg_hi;
  assign w_sw_off     = w_off_sw_lo | w_off_sw_hi;
  assign w_mapped     = w_writable | w_sw_off;
  assign w_wr_en      = bus.iDoIoWrite & w_in_win & w_writable;

  // A simultaneous read+write still performs the write; only the flag records it.
  assign w_fault_evt = w_hit & (bus.iAddress[0] | ~w_mapped |
                                (bus.iDoIoWrite & w_sw_off) |
                                (bus.iDoIoRead & bus.iDoIoWrite));

  assign w_unused_wdata = ^bus.iWriteData[31:16];

  always_comb begin
    w_rd_data = 16'h0000;
    if (bus.iDoIoRead && w_in_win) begin
      case (w_off)
        10'h060: w_rd_data = r_led[15:0];
        10'h062: w_rd_data = {8'h00, r_led[23:16]};
        10'h070: w_rd_data = r_stable[15:0];
        10'h072: w_rd_data = {8'h00, r_stable[23:16]};
        10'h080: w_rd_data = r_seg[15:0];
        10'h082: w_rd_data = r_seg[31:16];
        default: w_rd_data = 16'h0000;
      endcase
    end
  end

  assign bus.oReadData = w_rd_data;

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_led   <= '0;
      r_seg   <= '0;
      r_fault <= 1'b0;
    end else begin
      if (w_wr_en) begin
        if (w_off_led_lo) r_led[15:0]  <= bus.iWriteData[15:0];
        if (w_off_led_hi) r_led[23:16] <= bus.iWriteData[7:0];
        if (w_off_seg_lo) r_seg[15:0]  <= bus.iWriteData[15:0];
        if (w_off_seg_hi) r_seg[31:16] <= bus.iWriteData[15:0];
      end
      if (w_fault_evt) r_fault <= 1'b1;
    end
  end

  // Debounce treats the 24 switches as one word; the counter saturates at DEB_MAX.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_cand    <= '0;
      r_stable  <= '0;
      r_deb_cnt <= '0;
    end else begin
      r_sync1 <= iSwitches;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_cand) begin
        r_cand    <= r_sync2;
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == DEB_MAX) begin
        r_stable <= r_cand;
      end else begin
        r_deb_cnt <= r_deb_cnt + 1'b1;
      end
    end
  end

  // Segment outputs are registered from the current index, so they trail it by a cycle.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_scan_cnt <= '0;
      r_idx      <= '0;
      r_seg_en   <= 8'hFE;
      r_seg_code <= 8'hC0;
    end else begin
      if (r_scan_cnt == SCAN_MAX) begin
        r_scan_cnt <= '0;
        r_idx      <= r_idx + 1'b1;
      end else begin
        r_scan_cnt <= r_scan_cnt + 1'b1;
      end
      r_seg_en   <= ~(8'h01 << r_idx);
      r_seg_code <= f_hex(r_seg[{r_idx, 2'b00} +: 4]);
    end
  end

  assign oLeds      = r_led;
  assign oSegEnable = r_seg_en;
  assign oSegCode   = r_seg_code;
  assign oIoFault   = r_fault;

endmodule

// File: tb/tb_io_port_controller.sv
// Self-checking bench for io_port_controller: directed scenarios plus a randomized
// bus/switch run, all compared against a sliding-window behavioural model.
module tb_io_port_controller;

  localparam logic [31:0] BASE = 32'hFFFFFC00;
  localparam int DEB  = 4;
  localparam int SCAN = 2;
  localparam int HN   = DEB + 3;

  logic        iClock = 1'b0;
  logic        iReset;
  logic [23:0] iSwitches;
  logic [23:0] oLeds;
  logic [7:0]  oSegEnable;
  logic [7:0]  oSegCode;
  logic        oIoFault;

  io_port_controller_if bus();

  io_port_controller #(
    .IO_BASE(BASE),
    .DEBOUNCE_CYCLES(DEB),
    .SCAN_CYCLES(SCAN)
  ) dut (
    .iClock(iClock),
    .iReset(iReset),
    .bus(bus),
    .iSwitches(iSwitches),
    .oLeds(oLeds),
    .oSegEnable(oSegEnable),
    .oSegCode(oSegCode),
    .oIoFault(oIoFault)
  );

  always #5 iClock = ~iClock;

  int checks = 0;
  int errors = 0;

  logic [7:0]  hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [23:0] led_m;
  logic [31:0] seg_m;
  logic        fault_m;
  logic [23:0] sw_m;
  logic [23:0] hist [HN];
  int          cyc;
  logic [7:0]  exp_en;
  logic [7:0]  exp_code;
  int          m_dig;
  logic        m_eq;
  logic [9:0]  m_off;
  logic        m_rd;
  logic        m_wr;

  // Reference model: switches become stable after DEB+1 consecutive equal raw samples
  // seen two edges late; the display digit is (edges since reset / SCAN) mod 8.
  always @(posedge iClock) begin
    if (iReset) begin
      led_m    = '0;
      seg_m    = '0;
      fault_m  = 1'b0;
      sw_m     = '0;
      cyc      = 0;
      exp_en   = 8'hFE;
      exp_code = 8'hC0;
      for (int i = 0; i < HN; i++) hist[i] = '0;
    end else begin
      m_dig    = (cyc / SCAN) % 8;
      exp_en   = 8'hFF ^ (8'h01 << m_dig);
      exp_code = hex_tab[seg_m[m_dig*4 +: 4]];
      cyc++;
      for (int i = HN - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = iSwitches;
      m_eq = 1'b1;
      for (int i = 3; i < HN; i++) if (hist[i] !== hist[2]) m_eq = 1'b0;
      if (m_eq) sw_m = hist[2];
      m_off = bus.iAddress[9:0];
      m_rd  = bus.iDoIoRead;
      m_wr  = bus.iDoIoWrite;
      if ((m_rd || m_wr) && bus.iAddress[31:10] == BASE[31:10]) begin
        if (bus.iAddress[0] ||
            !(m_off inside {10'h060, 10'h062, 10'h070, 10'h072, 10'h080, 10'h082}) ||
            (m_wr && (m_off inside {10'h070, 10'h072})) || (m_rd && m_wr))
          fault_m = 1'b1;
        if (m_wr) begin
          case (m_off)
            10'h060: led_m[15:0]  = bus.iWriteData[15:0];
            10'h062: led_m[23:16] = bus.iWriteData[7:0];
            10'h080: seg_m[15:0]  = bus.iWriteData[15:0];
            10'h082: seg_m[31:16] = bus.iWriteData[15:0];
            default: ;
          endcase
        end
      end
    end
  end

  function automatic logic [15:0] exp_read();
    logic [15:0] v;
    v = 16'h0000;
    if (bus.iDoIoRead && bus.iAddress[31:10] == BASE[31:10]) begin
      case (bus.iAddress[9:0])
        10'h060: v = led_m[15:0];
        10'h062: v = {8'h00, led_m[23:16]};
        10'h070: v = sw_m[15:0];
        10'h072: v = {8'h00, sw_m[23:16]};
        10'h080: v = seg_m[15:0];
        10'h082: v = seg_m[31:16];
        default: v = 16'h0000;
      endcase
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge iClock);
    @(negedge iClock);
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [15:0] d);
    bus.iDoIoRead  = rd;
    bus.iDoIoWrite = wr;
    bus.iAddress   = a;
    bus.iWriteData = {16'hDEAD, d};
  endtask

  task automatic do_reset();
    iReset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 16'h0);
    tick();
    iReset = 1'b0;
  endtask

  task automatic test_reset();
    iReset = 1'b1;
    drive(1'b0, 1'b1, BASE | 32'h060, 16'hFFFF);
    tick();
    tick();
    iReset = 1'b0;
    drive(1'b1, 1'b0, BASE | 32'h070, 16'h0);
    #1;
    checks++; if (oLeds !== 24'h0) begin errors++; $display("FAIL reset_leds got %h want %h", oLeds, 24'h0); end
    checks++; if (oIoFault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b want 0", oIoFault); end
    checks++; if (oSegEnable !== 8'hFE) begin errors++; $display("FAIL reset_segen got %h want FE", oSegEnable); end
    checks++; if (oSegCode !== 8'hC0) begin errors++; $display("FAIL reset_segcode got %h want C0", oSegCode); end
    checks++; if (bus.oReadData !== 16'h0000) begin errors++; $display("FAIL reset_sw_read got %h want 0000", bus.oReadData); end
    drive(1'b0, 1'b0, 32'h0, 16'h0);
  endtask

  task automatic test_led();
    do_reset();
    drive(1'b0, 1'b1, BASE | 32'h060, 16'hA5C3);
    tick();
    drive(1'b0, 1'b1, BASE | 32'h062, 16'h12FF);
    tick();
    drive(1'b1, 1'b0, BASE | 32'h062, 16'h0);
    #1;
    checks++; if (oLeds !== 24'hFFA5C3) begin errors++; $display("FAIL led_value got %h want FFA5C3", oLeds); end
    checks++; if (bus.oReadData !== 16'h00FF) begin errors++; $display("FAIL led_hi_read got %h want 00FF", bus.oReadData); end
    drive(1'b1, 1'b0, BASE | 32'h060, 16'h0);
    #1;
    checks++; if (bus.oReadData !== 16'hA5C3) begin errors++; $display("FAIL led_lo_read got %h want A5C3", bus.oReadData); end
    checks++; if (oIoFault !== 1'b0) begin errors++; $display("FAIL led_fault got %b want 0", oIoFault); end
    drive(1'b0, 1'b0, 32'h0, 16'h0);
  endtask

  task automatic test_debounce();
    int first;
    do_reset();
    iSwitches = 24'h00BEEF;
    drive(1'b1, 1'b0, BASE | 32'h070, 16'h0);
    first = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      #1;
      checks++; if (bus.oReadData !== exp_read()) begin errors++; $display("FAIL deb_rise cyc %0d got %h want %h", i, bus.oReadData, exp_read()); end
      if (first < 0 && bus.oReadData == 16'hBEEF) first = i;
    end
    // two synchroniser edges, one candidate load, then DEB counted edges
    checks++; if (first !== 7) begin errors++; $display("FAIL deb_latency got %0d want 7", first); end
    iSwitches = 24'h000000;
    tick();
    iSwitches = 24'h00BEEF;
    for (int i = 0; i < 10; i++) begin
      tick();
      #1;
      checks++; if (bus.oReadData !== 16'hBEEF) begin errors++; $display("FAIL deb_glitch cyc %0d got %h want BEEF", i, bus.oReadData); end
    end
    checks++; if (oIoFault !== 1'b0) begin errors++; $display("FAIL deb_fault got %b want 0", oIoFault); end
    for (int r = 0; r < 10; r++) begin
      int hold;
      iSwitches = 24'($urandom);
      hold = $urandom_range(1, 9);
      for (int i = 0; i < hold; i++) begin
        drive(1'b1, 1'b0, BASE | ((i % 2 == 0) ? 32'h070 : 32'h072), 16'h0);
        tick();
        #1;
        checks++; if (bus.oReadData !== exp_read()) begin errors++; $display("FAIL deb_rand r%0d got %h want %h", r, bus.oReadData, exp_read()); end
      end
    end
    drive(1'b0, 1'b0, 32'h0, 16'h0);
  endtask

  task automatic test_scan();
    logic seen7;
    do_reset();
    drive(1'b0, 1'b1, BASE | 32'h080, 16'h3210);
    tick();
    drive(1'b0, 1'b1, BASE | 32'h082, 16'h7654);
    tick();
    drive(1'b0, 1'b0, 32'h0, 16'h0);
    seen7 = 1'b0;
    for (int i = 0; i < 36; i++) begin
      #1;
      checks++; if (oSegEnable !== exp_en) begin errors++; $display("FAIL scan_en cyc %0d got %h want %h", i, oSegEnable, exp_en); end
      checks++; if (oSegCode !== exp_code) begin errors++; $display("FAIL scan_code cyc %0d got %h want %h", i, oSegCode, exp_code); end
      if (oSegEnable == 8'h7F && oSegCode == 8'hF8) seen7 = 1'b1;
      tick();
    end
    checks++; if (seen7 !== 1'b1) begin errors++; $display("FAIL scan_digit7 got %b want 1", seen7); end
  endtask

  task automatic test_faults();
    do_reset();
    drive(1'b0, 1'b1, BASE | 32'h070, 16'h5555);
    tick();
    drive(1'b0, 1'b0, 32'h0, 16'h0);
    #1;
    checks++; if (oIoFault !== 1'b1) begin errors++; $display("FAIL fault_wr_sw got %b want 1", oIoFault); end
    checks++; if (oLeds !== 24'h0) begin errors++; $display("FAIL fault_wr_sw_leds got %h want 0", oLeds); end
    do_reset();
    drive(1'b1, 1'b0, BASE | 32'h064, 16'h0);
    #1;
    checks++; if (bus.oReadData !== 16'h0000) begin errors++; $display("FAIL fault_unmapped_data got %h want 0000", bus.oReadData); end
    tick();
    drive(1'b0, 1'b0, 32'h0, 16'h0);
    #1;
    checks++; if (oIoFault !== 1'b1) begin errors++; $display("FAIL fault_unmapped got %b want 1", oIoFault); end
    do_reset();
    drive(1'b1, 1'b0, 32'hFFFFFC61, 16'h0);
    #1;
    checks++; if (bus.oReadData !== 16'h0000) begin errors++; $display("FAIL fault_odd_data got %h want 0000", bus.oReadData); end
    tick();
    drive(1'b0, 1'b0, 32'h0, 16'h0);
    #1;
    checks++; if (oIoFault !== 1'b1) begin errors++; $display("FAIL fault_odd got %b want 1", oIoFault); end
    do_reset();
    drive(1'b0, 1'b1, BASE | 32'h060, 16'h7777);
    tick();
    drive(1'b1, 1'b0, 32'h10000060, 16'h0);
    #1;
    checks++; if (bus.oReadData !== 16'h0000) begin errors++; $display("FAIL outside_data got %h want 0000", bus.oReadData); end
    tick();
    drive(1'b0, 1'b0, 32'h0, 16'h0);
    #1;
    checks++; if (oIoFault !== 1'b0) begin errors++; $display("FAIL outside_fault got %b want 0", oIoFault); end
  endtask

  task automatic test_rdwr();
    do_reset();
    drive(1'b1, 1'b1, BASE | 32'h080, 16'h1234);
    #1;
    checks++; if (bus.oReadData !== 16'h0000) begin errors++; $display("FAIL rdwr_pre got %h want 0000", bus.oReadData); end
    tick();
    drive(1'b1, 1'b0, BASE | 32'h080, 16'h0);
    #1;
    checks++; if (bus.oReadData !== 16'h1234) begin errors++; $display("FAIL rdwr_post got %h want 1234", bus.oReadData); end
    checks++; if (oIoFault !== 1'b1) begin errors++; $display("FAIL rdwr_fault got %b want 1", oIoFault); end
    drive(1'b0, 1'b0, 32'h0, 16'h0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1'b0, 1'b1, BASE | 32'h060, 16'h3456);
    tick();
    drive(1'b0, 1'b1, BASE | 32'h062, 16'h0012);
    tick();
    drive(1'b0, 1'b0, 32'h0, 16'h0);
    #1;
    checks++; if (oLeds !== 24'h123456) begin errors++; $display("FAIL mid_leds_pre got %h want 123456", oLeds); end
    iSwitches = 24'hA5A5A5;
    for (int i = 0; i < 5; i++) tick();
    drive(1'b1, 1'b0, BASE | 32'h064, 16'h0);
    tick();
    iReset = 1'b1;
    drive(1'b0, 1'b1, BASE | 32'h060, 16'hFFFF);
    tick();
    drive(1'b1, 1'b0, BASE | 32'h070, 16'h0);
    #1;
    checks++; if (oLeds !== 24'h0) begin errors++; $display("FAIL mid_leds got %h want 000000", oLeds); end
    checks++; if (oIoFault !== 1'b0) begin errors++; $display("FAIL mid_fault got %b want 0", oIoFault); end
    checks++; if (oSegEnable !== 8'hFE) begin errors++; $display("FAIL mid_segen got %h want FE", oSegEnable); end
    checks++; if (oSegCode !== 8'hC0) begin errors++; $display("FAIL mid_segcode got %h want C0", oSegCode); end
    checks++; if (bus.oReadData !== 16'h0000) begin errors++; $display("FAIL mid_sw_read got %h want 0000", bus.oReadData); end
    iReset = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 16'h0);
  endtask

  task automatic test_random();
    logic [9:0] offs [11] = '{10'h060, 10'h062, 10'h070, 10'h072, 10'h080, 10'h082,
                              10'h064, 10'h061, 10'h083, 10'h3FE, 10'h000};
    logic [31:0] a;
    int k;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      iReset = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 5) == 0) iSwitches = 24'($urandom);
      a = {($urandom_range(0, 9) == 0) ? 22'h040000 : BASE[31:10], offs[$urandom_range(0, 10)]};
      k = $urandom_range(0, 7);
      drive(k inside {1, 2, 7}, k inside {3, 4, 5, 7}, a, 16'($urandom));
      #1;
      checks++; if (bus.oReadData !== exp_read()) begin errors++; $display("FAIL rand_read n%0d a=%h got %h want %h", n, a, bus.oReadData, exp_read()); end
      tick();
      #1;
      checks++; if (oLeds !== led_m) begin errors++; $display("FAIL rand_leds n%0d got %h want %h", n, oLeds, led_m); end
      checks++; if (oIoFault !== fault_m) begin errors++; $display("FAIL rand_fault n%0d got %b want %b", n, oIoFault, fault_m); end
      checks++; if (oSegEnable !== exp_en || oSegCode !== exp_code) begin errors++; $display("FAIL rand_seg n%0d got %h/%h want %h/%h", n, oSegEnable, oSegCode, exp_en, exp_code); end
    end
    iReset = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 16'h0);
  endtask

  initial begin
    iReset    = 1'b1;
    iSwitches = 24'h0;
    drive(1'b0, 1'b0, 32'h0, 16'h0);
    @(negedge iClock);
    test_reset();
    test_led();
    test_debounce();
    test_scan();
    test_faults();
    test_rdwr();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
